// File: rtl/mux_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_stream_pkg
// Description : Shared types and helpers for the N-channel stream multiplexer
//               (mode encoding and round-robin pointer wrap).
// Revision    : 1.0 - initial release
// ============================================================================
package mux_stream_pkg;

  // Operating mode of the multiplexer, taken straight from the mode pin.
  typedef enum logic {
    MODE_SEL = 1'b0,   // channel picked by the sel input
    MODE_RR  = 1'b1    // fair round-robin across requesting channels
  } mux_mode_t;

  // Round-robin successor of a channel index: the channel after idx, wrapping
  // from the last channel (n-1) back to channel 0.
  function automatic int rr_next(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage : mux_stream_pkg
`default_nettype wire

// File: rtl/mux_stream_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Grants the first asserted
//               request found searching upward from ptr, wrapping N-1 -> 0.
//               Produces a one-hot grant, its index, and an any-grant flag.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N    = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] gidx,
  output logic            any
);

  // Rotating priority search: offset k visits channel (ptr + k) mod N; the
  // first requester wins. ptr is always < N, so one subtraction of N suffices.
  always_comb begin
    logic [SELW:0]   v_sum;
    logic [SELW-1:0] v_idx;
    grant = '0;
    gidx  = '0;
    any   = 1'b0;
    v_sum = '0;
    v_idx = '0;
    for (int k = 0; k < N; k++) begin
      v_sum = {1'b0, ptr} + (SELW+1)'(k);
      if (v_sum >= (SELW+1)'(N)) begin
        v_sum = v_sum - (SELW+1)'(N);
      end
      v_idx = v_sum[SELW-1:0];
      if (!any && req[v_idx]) begin
        grant[v_idx] = 1'b1;
        gidx         = v_idx;
        any          = 1'b1;
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/mux_stream_rr.sv
`default_nettype none
// ============================================================================
// Module      : mux_stream_rr
// Description : N-channel, WIDTH-bit valid/ready stream multiplexer with a
//               single registered output stage. Channel choice is either an
//               explicit select or fair round-robin. Full throughput: a
//               consumer pop and a new load may happen in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_stream_rr
  import mux_stream_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int N     = 4,
  localparam int SELW  = $clog2(N)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel,
  input  logic [N-1:0]              in_valid,
  input  logic [N-1:0][WIDTH-1:0]   in_data,
  output logic [N-1:0]              in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_src,
  input  logic                      out_ready
);

  mux_mode_t       w_mode;
  logic [N-1:0]    w_sel_grant;
  logic [N-1:0]    w_rr_grant;
  logic [SELW-1:0] w_rr_gidx;
  logic            w_rr_any;
  logic [N-1:0]    w_grant;
  logic [SELW-1:0] w_gidx;
  logic            w_any;
  logic            w_load;
  logic            w_xfer;

  logic            r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SELW-1:0] r_out_src;
  logic [SELW-1:0] r_ptr;

  assign w_mode = mux_mode_t'(mode);

  // The output register can take a new word when it is empty or being popped.
  assign w_load = ~r_out_valid | out_ready;

  // Explicit-select grant: each bit looks only at its own valid, so in_ready
  // never depends on another channel's valid. An out-of-range sel matches no
  // channel and therefore grants nothing.
  for (genvar gi = 0; gi < N; gi++) begin : g_sel
    assign w_sel_grant[gi] = in_valid[gi] & (sel == SELW'(gi));
  end

  rr_arbiter #(
    .N    (N),
    .SELW (SELW)
  ) u_rr_arbiter (
    .req   (in_valid),
    .ptr   (r_ptr),
    .grant (w_rr_grant),
    .gidx  (w_rr_gidx),
    .any   (w_rr_any)
  );

  // Mode mux: choose which grant source drives the handshake this cycle.
  always_comb begin
    w_grant = w_sel_grant;
    w_gidx  = sel;
    w_any   = |w_sel_grant;
    if (w_mode == MODE_RR) begin
      w_grant = w_rr_grant;
      w_gidx  = w_rr_gidx;
      w_any   = w_rr_any;
    end
  end

  assign w_xfer = w_any & w_load;

  // in_ready is forced low while reset is held so no producer sees an accept.
  assign in_ready = w_grant & {N{w_load & reset_n}};

  // Output register: load on transfer, drain on pop, otherwise hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= in_data[w_gidx];
      r_out_src   <= w_gidx;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Round-robin pointer: moves just past the served channel, RR transfers only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (w_xfer && (w_mode == MODE_RR)) begin
      r_ptr <= SELW'(rr_next(int'(w_gidx), N));
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;

endmodule : mux_stream_rr
`default_nettype wire

// File: tb/tb_mux_stream_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_stream_rr
// Description : Self-checking bench for mux_stream_rr. A behavioural model
//               (plain integers) predicts in_ready and the output register
//               every cycle; directed scenarios add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_stream_rr;
  import mux_stream_pkg::*;

  localparam int WIDTH = 4;
  localparam int N     = 4;
  localparam int SELW  = 2;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic                    mode;
  logic [SELW-1:0]         sel;
  logic [N-1:0]            in_valid;
  logic [N-1:0][WIDTH-1:0] in_data;
  logic [N-1:0]            in_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [SELW-1:0]         out_src;
  logic                    out_ready;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state
  bit        m_valid;
  int        m_data;
  int        m_src;
  int        m_ptr;

  always #5 clk = ~clk;

  mux_stream_rr #(.WIDTH(WIDTH), .N(N)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_src = 0; m_ptr = 0;
  endtask

  // Channel the rules say should be granted now, or -1 for none.
  function automatic int model_grant();
    if (mode == 1'b0) begin
      return (int'(sel) < N && in_valid[sel]) ? int'(sel) : -1;
    end
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (in_valid[i]) return i;
    end
    return -1;
  endfunction

  // One clock: check DUT against model mid-cycle, then advance the model.
  task automatic cycle();
    int  g;
    bit  ld;
    logic [N-1:0] exp_rdy;
    #1;
    g  = model_grant();
    ld = !m_valid || out_ready;
    exp_rdy = (g >= 0 && ld) ? (N'(1) << g) : '0;
    chk("in_ready",  in_ready,  exp_rdy);
    chk("out_valid", out_valid, m_valid);
    chk("out_data",  out_data,  m_data);
    chk("out_src",   out_src,   m_src);
    @(posedge clk);
    if (exp_rdy != 0) begin
      m_data  = int'(in_data[g]);
      m_src   = g;
      m_valid = 1;
      if (mode == 1'b1) m_ptr = (g + 1) % N;
    end else if (out_ready) begin
      m_valid = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data,  0);
    chk("rst_out_src",   out_src,   0);
    chk("rst_in_ready",  in_ready,  0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n   = 1'b0;
    mode      = 1'b0;
    sel       = '0;
    in_valid  = 4'b1111;
    in_data   = '0;
    out_ready = 1'b1;
    @(negedge clk);
    do_reset();

    // Explicit select of channel 2 with every channel valid.
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1111;
    in_data = {4'h4, 4'hA, 4'h2, 4'h1};
    out_ready = 1'b1;
    #1;
    chk("sel_ready_lit", in_ready, 4'b0100);
    cycle();
    chk("sel_valid_lit", out_valid, 1);
    chk("sel_data_lit",  out_data, 4'hA);
    chk("sel_src_lit",   out_src, 2);

    // Round-robin with all channels valid: 1,2,3,4,1 with wrap.
    mode = 1'b1; in_valid = 4'b1111;
    in_data = {4'h4, 4'h3, 4'h2, 4'h1};
    begin
      int exp_d[5] = '{1, 2, 3, 4, 1};
      int exp_s[5] = '{0, 1, 2, 3, 0};
      for (int k = 0; k < 5; k++) begin
        cycle();
        chk("rr_seq_data_lit", out_data, exp_d[k]);
        chk("rr_seq_src_lit",  out_src,  exp_s[k]);
      end
    end

    // Backpressure for three cycles, then release with no bubble.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("bp_data_lit",  out_data, 1);
      chk("bp_ready_lit", in_ready, 4'b0000);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready_lit", in_ready, 4'b0010);
    cycle();
    chk("bp_release_data_lit",  out_data, 2);
    chk("bp_release_valid_lit", out_valid, 1);

    // Single requester on channel 3 from ptr 0, then ptr wraps to 0.
    do_reset();
    mode = 1'b1; in_valid = 4'b1000; out_ready = 1'b1;
    in_data = {4'h9, 4'h3, 4'h2, 4'h1};
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("single_src_lit", out_src, 3);
      chk("single_data_lit", out_data, 4'h9);
    end
    in_valid = 4'b1111;
    #1;
    chk("single_wrap_lit", in_ready, 4'b0001);
    cycle();

    // Mode switch RR -> SEL while holding data under backpressure.
    out_ready = 1'b0; mode = 1'b0; sel = 2'd3;
    in_data = {4'hC, 4'h7, 4'h6, 4'h5};
    cycle();
    chk("switch_hold_data_lit", out_data, 4'h1);
    chk("switch_hold_src_lit",  out_src, 0);
    out_ready = 1'b1;
    #1;
    chk("switch_sel_ready_lit", in_ready, 4'b1000);
    cycle();
    chk("switch_sel_data_lit", out_data, 4'hC);

    // Asynchronous reset in the middle of a cycle with out_valid high.
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_valid_lit", out_valid, 0);
    chk("async_data_lit",  out_data, 0);
    chk("async_src_lit",   out_src, 0);
    chk("async_ready_lit", in_ready, 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    #1;
    chk("async_ptr0_lit", in_ready, 4'b0001);
    cycle();

    // Randomized traffic checked against the model every cycle.
    for (int k = 0; k < 600; k++) begin
      mode      = 1'($urandom_range(0, 1));
      sel       = SELW'($urandom_range(0, N - 1));
      in_valid  = N'($urandom);
      in_data   = (N*WIDTH)'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_mux_stream_rr
`default_nettype wire
